// File: rtl/mskaes_share_loader_pkg.sv
// Shared definitions for the masked AES share loader.
// Contents: block geometry constants, the loader state enum and a helper
// that gives the width of one bit-interleaved shared word for a core share
// count d.
// Optional feature macro: MSKAES_LOADER_KEY_REUSE_EN (used by the top).
package mskaes_share_loader_pkg;

  localparam int unsigned MSKAES_WORDS_PER_BLOCK = 4;
  localparam int unsigned MSKAES_BEATS           = 8;
  localparam int unsigned MSKAES_WORD_BITS       = 32;

  // Default core share count and the matching shared word width.
  localparam int unsigned MSKAES_DEFAULT_D        = 4;
  localparam int unsigned MSKAES_DEFAULT_SH_WORD_W = MSKAES_WORD_BITS * MSKAES_DEFAULT_D / 2;

  typedef enum logic [0:0] {
    LOAD,
    FULL
  } loader_state_e;

  // Width of one 32-bit word carrying d/2 shares per bit.
  function automatic int unsigned mskaes_sh_word_w(input int unsigned d);
    return MSKAES_WORD_BITS * d / 2;
  endfunction

endpackage

// File: rtl/mskaes_word_buffer.sv
// Four-word shared register file used as a key or plaintext block buffer.
// Ports:
//   clk, nrst   clock, asynchronous active-low reset (clears contents)
//   clr         synchronous clear of all four words (wins over writes)
//   we          per-word write enable
//   wdata       shared word to write
//   data        all four words, word w at [w*W +: W]
module mskaes_word_buffer
  import mskaes_share_loader_pkg::*;
#(
  parameter int unsigned W = MSKAES_DEFAULT_SH_WORD_W
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                clr,
  input  logic [MSKAES_WORDS_PER_BLOCK-1:0]   we,
  input  logic [W-1:0]                        wdata,
  output logic [MSKAES_WORDS_PER_BLOCK*W-1:0] data
);

  logic [MSKAES_WORDS_PER_BLOCK-1:0][W-1:0] mem_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem_q <= '0;
    end else if (clr) begin
      mem_q <= '0;
    end else begin
      for (int w = 0; w < MSKAES_WORDS_PER_BLOCK; w++) begin
        if (we[w]) mem_q[w] <= wdata;
      end
    end
  end

  assign data = mem_q;

endmodule

// File: rtl/mskaes_share_loader.sv
// Word-serial share loader in front of the round-based masked AES-128 core.
// Collects a 2-share key (beats 0-3) and plaintext (beats 4-7), presents the
// block on the core valid_in/ready handshake, and scrubs the buffers on issue
// so stale shares do not linger. Only one block may be in the core at a time.
// Ports:
//   clk, nrst              clock, asynchronous active-low reset
//   in_valid/in_ready      beat handshake
//   in_sh_word             one shared word, share s of bit i at [i*d/2+s]
//   in_key_keep            beat-0 key reuse request
//   core_ready             core ready
//   core_valid_in          block offered to the core
//   core_sh_key            buffered shared key
//   core_sh_plaintext      buffered shared plaintext
//   core_cipher_valid      core result pulse, ends the in-flight block
//   busy                   a block is in flight in the core
// Optional feature: MSKAES_LOADER_KEY_REUSE_EN enables keeping the previous
// key (beat 0 with in_key_keep jumps straight to plaintext; key not scrubbed).
module mskaes_share_loader
  import mskaes_share_loader_pkg::*;
#(
  parameter int unsigned d = MSKAES_DEFAULT_D
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [MSKAES_WORD_BITS*d/2-1:0]   in_sh_word,
  input  logic                              in_key_keep,
  input  logic                              core_ready,
  output logic                              core_valid_in,
  output logic [4*MSKAES_WORD_BITS*d/2-1:0] core_sh_key,
  output logic [4*MSKAES_WORD_BITS*d/2-1:0] core_sh_plaintext,
  input  logic                              core_cipher_valid,
  output logic                              busy
);

  localparam int unsigned ShW = mskaes_sh_word_w(d);

  loader_state_e state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [MSKAES_WORDS_PER_BLOCK-1:0] key_we, pt_we;
  logic          key_clr, pt_clr;
  logic          reuse_beat;
  logic          key_scrub;

`ifdef MSKAES_LOADER_KEY_REUSE_EN
  logic key_loaded_q, key_loaded_d;

  assign reuse_beat = in_key_keep & key_loaded_q & (cnt_q == 3'd0);
  assign key_scrub  = 1'b0;

  always_comb begin
    key_loaded_d = key_loaded_q;
    if (in_valid && in_ready && (cnt_q == 3'd3)) key_loaded_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) key_loaded_q <= 1'b0;
    else       key_loaded_q <= key_loaded_d;
  end
`else
  logic unused_key_keep;

  assign unused_key_keep = in_key_keep;
  assign reuse_beat      = 1'b0;
  assign key_scrub       = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    key_we        = '0;
    pt_we         = '0;
    key_clr       = 1'b0;
    pt_clr        = 1'b0;
    in_ready      = 1'b0;
    core_valid_in = 1'b0;

    // Spurious pulses while idle are harmless: busy_q is already 0.
    if (core_cipher_valid) busy_d = 1'b0;

    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (reuse_beat) begin
            // Beat 0 carries plaintext word 0; skip the key beats.
            pt_we[0] = 1'b1;
            cnt_d    = 3'd5;
          end else begin
            if (!cnt_q[2]) key_we[cnt_q[1:0]] = 1'b1;
            else           pt_we[cnt_q[1:0]]  = 1'b1;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d = FULL;
              cnt_d   = 3'd0;
            end
          end
        end
      end
      FULL: begin
        // busy gates the offer, so an issue never meets a busy clear.
        core_valid_in = ~busy_q;
        if (!busy_q && core_ready) begin
          pt_clr  = 1'b1;
          key_clr = key_scrub;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= LOAD;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

  mskaes_word_buffer #(
    .W (ShW)
  ) u_key_buf (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (key_clr),
    .we    (key_we),
    .wdata (in_sh_word),
    .data  (core_sh_key)
  );

  mskaes_word_buffer #(
    .W (ShW)
  ) u_pt_buf (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (pt_clr),
    .we    (pt_we),
    .wdata (in_sh_word),
    .data  (core_sh_plaintext)
  );

endmodule

// File: tb/tb_mskaes_share_loader.sv
// Self-checking bench for mskaes_share_loader (d = 4, two shares per bit).
// Expected buffer contents are built from 128-bit block values and random
// masks; expected control behaviour follows the block-level rules.
module tb_mskaes_share_loader;

  localparam int unsigned D  = 4;
  localparam int unsigned SW = 32 * D / 2;

  logic            clk = 1'b0;
  logic            nrst;
  logic            in_valid;
  logic            in_ready;
  logic [SW-1:0]   in_sh_word;
  logic            in_key_keep;
  logic            core_ready;
  logic            core_valid_in;
  logic [4*SW-1:0] core_sh_key;
  logic [4*SW-1:0] core_sh_plaintext;
  logic            core_cipher_valid;
  logic            busy;

  int total = 0;
  int bad   = 0;

  mskaes_share_loader #(
    .d (D)
  ) dut (
    .clk               (clk),
    .nrst              (nrst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_sh_word        (in_sh_word),
    .in_key_keep       (in_key_keep),
    .core_ready        (core_ready),
    .core_valid_in     (core_valid_in),
    .core_sh_key       (core_sh_key),
    .core_sh_plaintext (core_sh_plaintext),
    .core_cipher_valid (core_cipher_valid),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit i: share 0 at [2i], share 1 (the mask) at [2i+1].
  function automatic logic [63:0] share_word(input logic [31:0] v, input logic [31:0] m);
    logic [63:0] r;
    for (int i = 0; i < 32; i++) begin
      r[2*i]   = v[i] ^ m[i];
      r[2*i+1] = m[i];
    end
    return r;
  endfunction

  function automatic logic [255:0] sh_block(input logic [127:0] v, input logic [127:0] m);
    logic [255:0] r;
    for (int w = 0; w < 4; w++) r[w*64 +: 64] = share_word(v[w*32 +: 32], m[w*32 +: 32]);
    return r;
  endfunction

  function automatic logic [127:0] unshare(input logic [255:0] s);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = s[2*i] ^ s[2*i+1];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send_beat(input logic [63:0] w, input logic keep);
    int n;
    n           = 0;
    in_valid    = 1'b1;
    in_sh_word  = w;
    in_key_keep = keep;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) check_eq("beat_timeout", 256'(in_ready), 256'd1);
    step();
    in_valid    = 1'b0;
    in_key_keep = 1'b0;
  endtask

  task automatic send_words(input logic [127:0] v, input logic [127:0] m,
                            input int first, input int last, input logic keep0);
    for (int w = first; w <= last; w++) begin
      send_beat(share_word(v[w*32 +: 32], m[w*32 +: 32]), (w == first) ? keep0 : 1'b0);
    end
  endtask

  task automatic issue_and_finish();
    core_ready = 1'b1;
    step();
    core_ready        = 1'b0;
    core_cipher_valid = 1'b1;
    step();
    core_cipher_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] k, p, mk, mp, k2, p2, mk2, mp2, p3, m3, p4, m4;
    int hs;
    int acc;
    int cyc;

    nrst              = 1'b0;
    in_valid          = 1'b0;
    in_sh_word        = '0;
    in_key_keep       = 1'b0;
    core_ready        = 1'b0;
    core_cipher_valid = 1'b0;
    #3;
    check_eq("rst_in_ready", 256'(in_ready), 256'd1);
    check_eq("rst_valid", 256'(core_valid_in), 256'd0);
    check_eq("rst_busy", 256'(busy), 256'd0);
    check_eq("rst_key", core_sh_key, 256'd0);
    check_eq("rst_pt", core_sh_plaintext, 256'd0);
    #9 nrst = 1'b1;
    step();

    // FIPS-197 block.
    k  = 128'h000102030405060708090a0b0c0d0e0f;
    p  = 128'h00112233445566778899aabbccddeeff;
    mk = rnd128();
    mp = rnd128();
    send_words(k, mk, 0, 3, 1'b0);
    send_words(p, mp, 0, 2, 1'b0);
    check_eq("fips_valid_early", 256'(core_valid_in), 256'd0);
    send_words(p, mp, 3, 3, 1'b0);
    check_eq("fips_valid", 256'(core_valid_in), 256'd1);
    check_eq("fips_in_ready", 256'(in_ready), 256'd0);
    check_eq("fips_key_xor", 256'(unshare(core_sh_key)), 256'(k));
    check_eq("fips_pt_xor", 256'(unshare(core_sh_plaintext)), 256'(p));
    check_eq("fips_key_sh", core_sh_key, sh_block(k, mk));
    check_eq("fips_pt_sh", core_sh_plaintext, sh_block(p, mp));

    // Ready held for 5 cycles: one fetch only.
    core_ready = 1'b1;
    hs = 0;
    if (core_valid_in && core_ready) hs++;
    step();
    check_eq("held_pt_scrub", core_sh_plaintext, 256'd0);
`ifdef MSKAES_LOADER_KEY_REUSE_EN
    check_eq("held_key_kept", core_sh_key, sh_block(k, mk));
`else
    check_eq("held_key_scrub", core_sh_key, 256'd0);
`endif
    check_eq("held_in_ready", 256'(in_ready), 256'd1);
    check_eq("held_busy", 256'(busy), 256'd1);
    repeat (4) begin
      if (core_valid_in && core_ready) hs++;
      step();
    end
    core_ready = 1'b0;
    check_eq("held_one_fetch", 256'(hs), 256'd1);

    // Early load while busy.
    k2  = rnd128();
    p2  = rnd128();
    mk2 = rnd128();
    mp2 = rnd128();
    send_words(k2, mk2, 0, 3, 1'b0);
    send_words(p2, mp2, 0, 3, 1'b0);
    check_eq("early_in_ready", 256'(in_ready), 256'd0);
    core_ready = 1'b1;
    hs = 0;
    repeat (3) begin
      if (core_valid_in) hs++;
      step();
    end
    core_ready = 1'b0;
    check_eq("early_no_issue", 256'(hs), 256'd0);
    core_cipher_valid = 1'b1;
    check_eq("early_valid_in_pulse", 256'(core_valid_in), 256'd0);
    step();
    core_cipher_valid = 1'b0;
    check_eq("early_busy_clr", 256'(busy), 256'd0);
    check_eq("early_valid", 256'(core_valid_in), 256'd1);
    check_eq("early_key", core_sh_key, sh_block(k2, mk2));
    check_eq("early_pt", core_sh_plaintext, sh_block(p2, mp2));
    issue_and_finish();
    check_eq("early_done_busy", 256'(busy), 256'd0);
    core_cipher_valid = 1'b1;
    step();
    core_cipher_valid = 1'b0;
    check_eq("spurious_cv_busy", 256'(busy), 256'd0);

    // Key reuse request on beat 0.
    p3 = rnd128();
    m3 = rnd128();
    send_words(p3, m3, 0, 3, 1'b1);
`ifdef MSKAES_LOADER_KEY_REUSE_EN
    check_eq("reuse_valid", 256'(core_valid_in), 256'd1);
    check_eq("reuse_key", core_sh_key, sh_block(k2, mk2));
    check_eq("reuse_pt", core_sh_plaintext, sh_block(p3, m3));
`else
    check_eq("noreuse_wait", 256'(core_valid_in), 256'd0);
    check_eq("noreuse_key", core_sh_key, sh_block(p3, m3));
    check_eq("noreuse_pt", core_sh_plaintext, 256'd0);
    p4 = rnd128();
    m4 = rnd128();
    send_words(p4, m4, 0, 3, 1'b0);
    check_eq("noreuse_valid", 256'(core_valid_in), 256'd1);
    check_eq("noreuse_pt_full", core_sh_plaintext, sh_block(p4, m4));
`endif
    issue_and_finish();

    // Back-pressure then asynchronous reset mid-load while busy.
    k  = rnd128();
    p  = rnd128();
    mk = rnd128();
    mp = rnd128();
    send_words(k, mk, 0, 3, 1'b0);
    send_words(p, mp, 0, 3, 1'b0);
    core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    k2  = rnd128();
    p2  = rnd128();
    mk2 = rnd128();
    mp2 = rnd128();
    acc = 0;
    cyc = 0;
    while (acc < 5 && cyc < 40) begin
      in_valid = (cyc % 2 == 0);
      if (acc < 4) in_sh_word = share_word(k2[acc*32 +: 32], mk2[acc*32 +: 32]);
      else         in_sh_word = share_word(p2[(acc-4)*32 +: 32], mp2[(acc-4)*32 +: 32]);
      if (in_valid && in_ready) acc++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("bp_cycles", 256'(cyc), 256'd9);
    check_eq("bp_key", core_sh_key, sh_block(k2, mk2));
    check_eq("bp_pt", core_sh_plaintext, {192'd0, share_word(p2[31:0], mp2[31:0])});
    check_eq("bp_busy", 256'(busy), 256'd1);
    #3 nrst = 1'b0;
    #1;
    check_eq("arst_in_ready", 256'(in_ready), 256'd1);
    check_eq("arst_busy", 256'(busy), 256'd0);
    check_eq("arst_valid", 256'(core_valid_in), 256'd0);
    check_eq("arst_key", core_sh_key, 256'd0);
    check_eq("arst_pt", core_sh_plaintext, 256'd0);
    @(negedge clk);
    nrst = 1'b1;
    step();
    send_words(k, mk, 0, 3, 1'b0);
    send_words(p, mp, 0, 2, 1'b0);
    check_eq("post_rst_7beats", 256'(core_valid_in), 256'd0);
    send_words(p, mp, 3, 3, 1'b0);
    check_eq("post_rst_valid", 256'(core_valid_in), 256'd1);
    check_eq("post_rst_key", 256'(unshare(core_sh_key)), 256'(k));
    check_eq("post_rst_pt", 256'(unshare(core_sh_plaintext)), 256'(p));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
